down_counter_32bit: RTL and testbench

- Synchronous, loadable 32-bit down counter and timer. It is the counting-down counterpart of the team's 32-bit up counter.
- It loads a preset, decrements once per enabled cycle to zero, and signals terminal count. It then either stops or auto-reloads.
- Used in the FP32 datapath for iteration and timeout control, for example multi-cycle divide or sqrt step counting.
- Fully synchronous: a single clock drives all flops, with no ripple clocking.

---
 rtl/down_counter_32bit.sv | 191 +++++++++++++++++++
 tb/tb_down_counter_32bit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter_32bit.sv
// ---------------------------------------------------------------------------
// down_counter_32bit
//   Loadable WIDTH-bit down counter / timer with terminal-count pulse and
//   optional auto-reload. Loads a preset, decrements once per enabled RUN
//   cycle to zero, pulses tc on the edge where Q leaves 1, then either stops
//   (one-shot, DONE) or restarts from the stored preset (auto-reload).
//
//   Optional feature macro: DOWN_COUNTER_PRESCALE_EN
//     When defined, adds parameter PRESCALE (default 4, min 1) and an
//     internal prescaler so Q decrements only on every PRESCALE-th enabled
//     RUN cycle. When undefined, every enabled RUN cycle decrements.
// ---------------------------------------------------------------------------
module down_counter_32bit #(
    parameter int WIDTH = 32
`ifdef DOWN_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_next_s;
    logic             tc_r;
    logic             tc_next_s;
    logic             busy_r;
    logic             busy_next_s;
    logic             step_s;      // this enabled RUN cycle is allowed to decrement
    logic             terminal_s;  // terminal event happens on the coming edge

`ifdef DOWN_COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST_C = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_next_s;

    // Decrement is allowed only when the prescaler reaches its last phase.
    always_comb begin
        if (presc_r == PRESC_LAST_C) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
    end

    // Prescaler advances only on enabled RUN cycles; clears on load and terminal event.
    always_comb begin
        presc_next_s = presc_r;
        if (load) begin
            presc_next_s = {PW{1'b0}};
        end else if ((state_r == st_run) && en) begin
            if (step_s || terminal_s) begin
                presc_next_s = {PW{1'b0}};
            end else begin
                presc_next_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            presc_next_s = presc_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_next_s;
        end
    end
`else
    // Without the prescaler every enabled RUN cycle decrements.
    always_comb begin
        step_s = 1'b1;
    end
`endif

    // Terminal event: enabled RUN step while Q is 1 and no load pre-empts it.
    always_comb begin
        if (!load && (state_r == st_run) && en && step_s && (count_r == ONE_C)) begin
            terminal_s = 1'b1;
        end else begin
            terminal_s = 1'b0;
        end
    end

    // Next-state, next-count and terminal-count decode; load outranks everything.
    always_comb begin
        state_next_s  = state_r;
        count_next_s  = count_r;
        reload_next_s = reload_r;
        tc_next_s     = 1'b0;
        if (load) begin
            count_next_s  = load_val;
            reload_next_s = load_val;
            if (load_val != ZERO_C) begin
                state_next_s = st_run;
            end else begin
                state_next_s = st_idle;
            end
        end else begin
            case (state_r)
                st_run: begin
                    if (en && step_s) begin
                        if (terminal_s) begin
                            tc_next_s = 1'b1;
                            if (auto_reload) begin
                                count_next_s = reload_r;
                                state_next_s = st_run;
                            end else begin
                                count_next_s = ZERO_C;
                                state_next_s = st_done;
                            end
                        end else if (count_r == ZERO_C) begin
                            // Unreachable in normal operation; never wrap below zero.
                            count_next_s = ZERO_C;
                            state_next_s = st_idle;
                        end else begin
                            count_next_s = count_r - ONE_C;
                        end
                    end else begin
                        count_next_s = count_r;
                    end
                end
                st_idle: begin
                    state_next_s = st_idle;
                end
                st_done: begin
                    state_next_s = st_done;
                end
                default: begin
                    state_next_s = st_idle;
                    count_next_s = ZERO_C;
                end
            endcase
        end
    end

    // busy is registered from the next state so it tracks RUN without a comb path.
    always_comb begin
        if (state_next_s == st_run) begin
            busy_next_s = 1'b1;
        end else begin
            busy_next_s = 1'b0;
        end
    end

    // State, count, preset and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= st_idle;
            count_r  <= ZERO_C;
            reload_r <= ZERO_C;
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            count_r  <= count_next_s;
            reload_r <= reload_next_s;
            tc_r     <= tc_next_s;
            busy_r   <= busy_next_s;
        end
    end

    assign Q    = count_r;
    assign tc   = tc_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_down_counter_32bit.sv
// ---------------------------------------------------------------------------
// tb_down_counter_32bit
//   Table-driven bench for down_counter_32bit with a scoreboard queue of
//   expected post-edge values plus hand-written asynchronous-reset sequence.
// ---------------------------------------------------------------------------
module tb_down_counter_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [31:0] load_val;
    logic        auto_reload;
    logic [31:0] Q;
    logic        tc;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        ld;
        logic [31:0] lv;
        logic        en;
        logic        ar;
        logic [31:0] q;
        logic        tc;
        logic        busy;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic        tc;
        logic        busy;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    down_counter_32bit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .Q           (Q),
        .tc          (tc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [31:0] lv, input logic e, input logic ar,
                       input logic [31:0] q, input logic t, input logic b, input string name);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = e; v.ar = ar;
        v.q = q; v.tc = t; v.busy = b; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle at the falling edge, push expectation, compare after the rising edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        load        = v.ld;
        load_val    = v.lv;
        en          = v.en;
        auto_reload = v.ar;
        e.q = v.q; e.tc = v.tc; e.busy = v.busy; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.name, ".Q"},    Q,           got.q);
        chk({got.name, ".tc"},   {31'd0, tc},   {31'd0, got.tc});
        chk({got.name, ".busy"}, {31'd0, busy}, {31'd0, got.busy});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 32'd0; auto_reload = 1'b0;
        #1;
        chk("reset.Q",    Q,           32'd0);
        chk("reset.tc",   {31'd0, tc},   32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef DOWN_COUNTER_PRESCALE_EN
        // Prescale 4: Q holds 2 for four enabled cycles, then 1 for four, then 0 with tc.
        add(1'b1, 32'd2, 1'b0, 1'b0, 32'd2, 1'b0, 1'b1, "ps_load");
        for (int i = 0; i < 3; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd2, 1'b0, 1'b1, "ps_hold2");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1, "ps_dec1");
        for (int i = 0; i < 3; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1, "ps_hold1");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, "ps_tc");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, "ps_done");
`else
        // One-shot from 5.
        add(1'b1, 32'd5, 1'b0, 1'b0, 32'd5, 1'b0, 1'b1, "os_load");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd4, 1'b0, 1'b1, "os_4");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd3, 1'b0, 1'b1, "os_3");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd2, 1'b0, 1'b1, "os_2");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1, "os_1");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, "os_tc");
        for (int i = 0; i < 10; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, "os_done");
        // Auto-reload from 3 (loaded out of DONE), then drop auto_reload mid-count.
        add(1'b1, 32'd3, 1'b0, 1'b1, 32'd3, 1'b0, 1'b1, "ar_load");
        for (int r = 0; r < 2; r++) begin
            add(1'b0, 32'd0, 1'b1, 1'b1, 32'd2, 1'b0, 1'b1, "ar_2");
            add(1'b0, 32'd0, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1, "ar_1");
            add(1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1, "ar_reload");
        end
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd2, 1'b0, 1'b1, "ar_off_2");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1, "ar_off_1");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, "ar_off_tc");
        // Enable gating from 4 with en 1,0,0,1,1,1.
        add(1'b1, 32'd4, 1'b0, 1'b0, 32'd4, 1'b0, 1'b1, "eg_load");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd3, 1'b0, 1'b1, "eg_en1");
        add(1'b0, 32'd0, 1'b0, 1'b0, 32'd3, 1'b0, 1'b1, "eg_en0a");
        add(1'b0, 32'd0, 1'b0, 1'b0, 32'd3, 1'b0, 1'b1, "eg_en0b");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd2, 1'b0, 1'b1, "eg_2");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1, "eg_1");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, "eg_tc");
        // Load of zero goes to IDLE and never produces tc.
        add(1'b1, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, "z_load");
        add(1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, "z_idle_a");
        add(1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, "z_idle_b");
        // Maximum preset.
        add(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, "max_load");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, "max_dec");
        // Load coinciding with a terminal event wins and suppresses tc.
        add(1'b1, 32'd1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1, "pri_load1");
        add(1'b1, 32'd7, 1'b1, 1'b0, 32'd7, 1'b0, 1'b1, "pri_load7");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd6, 1'b0, 1'b1, "pri_6");
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Asynchronous reset in the middle of a count.
        vecs.delete();
        add(1'b1, 32'd10, 1'b0, 1'b0, 32'd10, 1'b0, 1'b1, "mr_load");
`ifdef DOWN_COUNTER_PRESCALE_EN
        for (int i = 0; i < 3; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd10, 1'b0, 1'b1, "mr_run");
`else
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd9, 1'b0, 1'b1, "mr_9");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd8, 1'b0, 1'b1, "mr_8");
        add(1'b0, 32'd0, 1'b1, 1'b0, 32'd7, 1'b0, 1'b1, "mr_7");
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("mr_async.Q",    Q,           32'd0);
        chk("mr_async.tc",   {31'd0, tc},   32'd0);
        chk("mr_async.busy", {31'd0, busy}, 32'd0);
        #1;
        rst = 1'b0;
        vecs.delete();
        for (int i = 0; i < 3; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, "mr_after");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
